// File: rtl/servo_pkg.sv
// Constants and types shared by the servo PWM generator and capture blocks.
package servo_pkg;

   localparam int unsigned TICKS_PER_US = 25;
   localparam int unsigned MIN_US       = 650;
   localparam int unsigned MAX_US       = 2600;
   localparam int unsigned DEG90_US     = 1625;
   localparam int unsigned TIMEOUT_US   = 25000;

   typedef enum logic [1:0] {S_SYNC, S_ARMED, S_HIGH, S_LOW} capture_state_t;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/pwm_in_sync.sv
// Synchronizer chain for an asynchronous pin, plus rise/fall strobes on the synchronized level.
module pwm_in_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_i,
   output logic valid_o,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;
   logic [STAGES:0]   fill_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         fill_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], async_i};
         prev_q <= sync_q[STAGES-1];
         fill_q <= {fill_q[STAGES-1:0], 1'b1};
      end
   end

   // The reset-cleared chain reads as a false low until real pin samples have filled it.
   assign valid_o = fill_q[STAGES];
   assign level_o = sync_q[STAGES-1];
   assign rise_o  = valid_o & level_o & ~prev_q;
   assign fall_o  = valid_o & ~level_o & prev_q;

endmodule

// File: rtl/servo_pwm_capture.sv
// Measures servo PWM high time and frame period in microseconds, with range check and loss detect.
module servo_pwm_capture #(
   parameter int unsigned TICKS_PER_US = servo_pkg::TICKS_PER_US,
   parameter int unsigned MIN_US       = servo_pkg::MIN_US,
   parameter int unsigned MAX_US       = servo_pkg::MAX_US,
   parameter int unsigned TIMEOUT_US   = servo_pkg::TIMEOUT_US,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        PWM_IN,
   output logic [15:0] pulse_us,
   output logic [15:0] period_us,
   output logic        sample_valid,
   output logic        range_err,
   output logic        lost
);
   import servo_pkg::*;

   localparam int unsigned TW        = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_US - 1);
   localparam logic [15:0] MIN_V     = 16'(MIN_US);
   localparam logic [15:0] MAX_V     = 16'(MAX_US);
   localparam logic [15:0] TIMEOUT_V = 16'(TIMEOUT_US);

   logic sync_valid, level, rise, fall;

   pwm_in_sync #(
      .STAGES(SYNC_STAGES)
   ) u_sync (
      .clk_i  (CLK),
      .rst_i  (RST),
      .async_i(PWM_IN),
      .valid_o(sync_valid),
      .level_o(level),
      .rise_o (rise),
      .fall_o (fall)
   );

   capture_state_t state_q;
   logic [TW-1:0]  tick_q;
   logic [15:0]    high_q, per_q, idle_q, shadow_q;
   logic [15:0]    pulse_q, period_q;
   logic           valid_q, rerr_q, lost_q;

   logic        us_strobe, any_edge, timeout;
   logic [15:0] high_inc, per_inc, idle_inc;

   // Counts include this cycle's strobe so an exact N-us interval reports N (floor rounding).
   assign us_strobe = (tick_q == TICK_LAST);
   assign any_edge  = rise | fall;
   assign high_inc  = us_strobe ? sat_inc(high_q) : high_q;
   assign per_inc   = us_strobe ? sat_inc(per_q) : per_q;
   assign idle_inc  = us_strobe ? sat_inc(idle_q) : idle_q;
   assign timeout   = !any_edge && (state_q != S_SYNC) && (idle_inc >= TIMEOUT_V);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= S_SYNC;
         tick_q   <= '0;
         high_q   <= '0;
         per_q    <= '0;
         idle_q   <= '0;
         shadow_q <= '0;
         pulse_q  <= '0;
         period_q <= '0;
         valid_q  <= 1'b0;
         rerr_q   <= 1'b0;
         lost_q   <= 1'b1;
      end else begin
         valid_q <= 1'b0;
         tick_q  <= (any_edge || us_strobe) ? '0 : tick_q + TW'(1);
         high_q  <= high_inc;
         per_q   <= per_inc;
         idle_q  <= any_edge ? '0 : idle_inc;

         unique case (state_q)
            S_SYNC: begin
               if (sync_valid && !level) state_q <= S_ARMED;
            end
            S_ARMED: begin
               if (rise) begin
                  high_q  <= '0;
                  per_q   <= '0;
                  state_q <= S_HIGH;
               end
            end
            S_HIGH: begin
               if (fall) begin
                  shadow_q <= high_inc;
                  state_q  <= S_LOW;
               end
            end
            S_LOW: begin
               if (rise) begin
                  pulse_q  <= shadow_q;
                  period_q <= per_inc;
                  rerr_q   <= (shadow_q < MIN_V) || (shadow_q > MAX_V);
                  valid_q  <= 1'b1;
                  lost_q   <= 1'b0;
                  high_q   <= '0;
                  per_q    <= '0;
                  state_q  <= S_HIGH;
               end
            end
            default: state_q <= S_SYNC;
         endcase

         // Clearing idle here stops a stale count re-triggering on every pass through S_ARMED.
         if (timeout) begin
            lost_q  <= 1'b1;
            idle_q  <= '0;
            state_q <= S_SYNC;
         end
      end
   end

   assign pulse_us     = pulse_q;
   assign period_us    = period_q;
   assign sample_valid = valid_q;
   assign range_err    = rerr_q;
   assign lost         = lost_q;

endmodule

// File: tb/tb_servo_pwm_capture.sv
// Directed bench for servo_pwm_capture; timing scaled to 2 ticks/us and a 3000 us timeout.
module tb_servo_pwm_capture;

   localparam int T    = 2;
   localparam int TO   = 3000;
   localparam int SYNC = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pwm = 1'b0;
   logic [15:0] pulse_us, period_us;
   logic        sample_valid, range_err, lost;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct packed {
      logic [15:0] pulse;
      logic [15:0] period;
      logic        rerr;
      logic        lost;
   } smp_t;

   smp_t q[$];

   servo_pwm_capture #(
      .TICKS_PER_US(T),
      .MIN_US      (650),
      .MAX_US      (2600),
      .TIMEOUT_US  (TO),
      .SYNC_STAGES (SYNC)
   ) dut (
      .CLK         (clk),
      .RST         (rst),
      .PWM_IN      (pwm),
      .pulse_us    (pulse_us),
      .period_us   (period_us),
      .sample_valid(sample_valid),
      .range_err   (range_err),
      .lost        (lost)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (sample_valid === 1'b1) q.push_back({pulse_us, period_us, range_err, lost});
   end

   // Drive a level for n cycles; caller is aligned to a falling edge.
   task automatic phase(input logic v, input int n);
      pwm = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      q.delete();
   endtask

   task automatic test_reset();
      pwm = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if (pulse_us !== 16'd0) begin
         n_fail++; $display("FAIL rst_pulse: got %0d want 0", pulse_us);
      end
      n_cmp++;
      if (period_us !== 16'd0) begin
         n_fail++; $display("FAIL rst_period: got %0d want 0", period_us);
      end
      n_cmp++;
      if (sample_valid !== 1'b0) begin
         n_fail++; $display("FAIL rst_valid: got %b want 0", sample_valid);
      end
      n_cmp++;
      if (range_err !== 1'b0) begin
         n_fail++; $display("FAIL rst_rerr: got %b want 0", range_err);
      end
      n_cmp++;
      if (lost !== 1'b1) begin
         n_fail++; $display("FAIL rst_lost: got %b want 1", lost);
      end
      repeat (20) @(negedge clk);
      n_cmp++;
      if (q.size() != 0 || lost !== 1'b1) begin
         n_fail++; $display("FAIL rst_idle: strobes %0d lost %b want 0 and 1", q.size(), lost);
      end
   endtask

   task automatic test_nominal();
      do_reset();
      phase(1'b0, 20);
      phase(1'b1, 1500 * T);
      phase(1'b0, 1000 * T);
      pwm = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (sample_valid !== 1'b0 || lost !== 1'b1) begin
         n_fail++; $display("FAIL nom_early: valid %b lost %b want 0 1", sample_valid, lost);
      end
      @(negedge clk);
      n_cmp++;
      if (sample_valid !== 1'b1 || lost !== 1'b0) begin
         n_fail++; $display("FAIL nom_strobe: valid %b lost %b want 1 0", sample_valid, lost);
      end
      n_cmp++;
      if (pulse_us !== 16'd1500 || period_us !== 16'd2500 || range_err !== 1'b0) begin
         n_fail++;
         $display("FAIL nom_first: got %0d/%0d/%b want 1500/2500/0", pulse_us, period_us,
                  range_err);
      end
      @(negedge clk);
      n_cmp++;
      if (sample_valid !== 1'b0 || pulse_us !== 16'd1500) begin
         n_fail++; $display("FAIL nom_one_cycle: valid %b pulse %0d want 0 1500",
                            sample_valid, pulse_us);
      end
      repeat (1500 * T - 4) @(negedge clk);
      phase(1'b0, 1000 * T);
      phase(1'b1, 20);
      n_cmp++;
      if (q.size() != 2) begin
         n_fail++; $display("FAIL nom_count: got %0d want 2", q.size());
      end else begin
         n_cmp++;
         if (q[1] !== {16'd1500, 16'd2500, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL nom_second: got %0d/%0d/%b want 1500/2500/0",
                               q[1].pulse, q[1].period, q[1].rerr);
         end
      end
   endtask

   task automatic test_range();
      int   w[4]    = '{650, 2600, 649, 2601};
      logic exp_e[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      smp_t s;
      do_reset();
      phase(1'b0, 20);
      for (int i = 0; i < 4; i++) begin
         phase(1'b1, w[i] * T);
         phase(1'b0, 100 * T);
      end
      phase(1'b1, 20);
      n_cmp++;
      if (q.size() != 4) begin
         n_fail++; $display("FAIL range_count: got %0d want 4", q.size());
      end
      for (int i = 0; i < 4; i++) begin
         s = (i < q.size()) ? q[i] : '1;
         n_cmp++;
         if (s.rerr !== exp_e[i] || s.pulse !== 16'(w[i]) || s.period !== 16'(w[i] + 100)) begin
            n_fail++;
            $display("FAIL range_%0d: got %0d/%0d/%b want %0d/%0d/%b", i, s.pulse, s.period,
                     s.rerr, w[i], w[i] + 100, exp_e[i]);
         end
      end
   endtask

   task automatic test_rounding();
      smp_t s;
      do_reset();
      phase(1'b0, 20);
      phase(1'b1, 1500 * T + T - 1);
      phase(1'b0, 100 * T);
      phase(1'b1, 1500 * T + T);
      phase(1'b0, 100 * T);
      phase(1'b1, 20);
      s = (q.size() > 0) ? q[0] : '1;
      n_cmp++;
      if (s.pulse !== 16'd1500 || s.period !== 16'd1600) begin
         n_fail++; $display("FAIL round_down: got %0d/%0d want 1500/1600", s.pulse, s.period);
      end
      s = (q.size() > 1) ? q[1] : '1;
      n_cmp++;
      if (s.pulse !== 16'd1501 || s.period !== 16'd1601) begin
         n_fail++; $display("FAIL round_up: got %0d/%0d want 1501/1601", s.pulse, s.period);
      end
   endtask

   task automatic test_lost();
      int lost_n = T * TO + SYNC + 1;
      int n0;
      smp_t s;
      do_reset();
      phase(1'b0, 20);
      phase(1'b1, 1500 * T);
      phase(1'b0, 1000 * T);
      phase(1'b1, 1500 * T);
      n_cmp++;
      if (lost !== 1'b0) begin
         n_fail++; $display("FAIL lost_pre: got %b want 0", lost);
      end
      n0 = q.size();
      pwm = 1'b0;
      for (int i = 1; i <= lost_n; i++) begin
         @(negedge clk);
         if (i == lost_n - 1) begin
            n_cmp++;
            if (lost !== 1'b0) begin
               n_fail++; $display("FAIL lost_early: got %b want 0 at cycle %0d", lost, i);
            end
         end
         if (i == lost_n) begin
            n_cmp++;
            if (lost !== 1'b1) begin
               n_fail++; $display("FAIL lost_edge: got %b want 1 at cycle %0d", lost, i);
            end
         end
      end
      n_cmp++;
      if (q.size() != n0 || pulse_us !== 16'd1500 || period_us !== 16'd2500) begin
         n_fail++; $display("FAIL lost_hold: strobes %0d pulse %0d period %0d want %0d 1500 2500",
                            q.size(), pulse_us, period_us, n0);
      end
      phase(1'b0, 20);
      phase(1'b1, 1500 * T);
      n_cmp++;
      if (q.size() != n0 || lost !== 1'b1) begin
         n_fail++; $display("FAIL lost_first_rise: strobes %0d lost %b want %0d 1",
                            q.size(), lost, n0);
      end
      phase(1'b0, 1000 * T);
      phase(1'b1, 20);
      s = (q.size() == n0 + 1) ? q[n0] : '1;
      n_cmp++;
      if (s !== {16'd1500, 16'd2500, 1'b0, 1'b0} || lost !== 1'b0) begin
         n_fail++; $display("FAIL lost_recover: got %0d/%0d lost %b want 1500/2500 0",
                            s.pulse, s.period, lost);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      phase(1'b0, 20);
      phase(1'b1, 1500 * T);
      phase(1'b0, 1000 * T);
      phase(1'b1, 300 * T);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      q.delete();
      n_cmp++;
      if (pulse_us !== 16'd0 || period_us !== 16'd0 || range_err !== 1'b0 || lost !== 1'b1 ||
          sample_valid !== 1'b0) begin
         n_fail++; $display("FAIL rmid_values: got %0d/%0d/%b/%b/%b want 0/0/0/1/0", pulse_us,
                            period_us, range_err, lost, sample_valid);
      end
      phase(1'b1, 100 * T);
      phase(1'b0, 100 * T);
      phase(1'b1, 1500 * T);
      n_cmp++;
      if (q.size() != 0) begin
         n_fail++; $display("FAIL rmid_partial: got %0d strobes want 0", q.size());
      end
      phase(1'b0, 500 * T);
      phase(1'b1, 20);
      n_cmp++;
      if (q.size() != 1 || q[0] !== {16'd1500, 16'd2000, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL rmid_first: strobes %0d want 1 of 1500/2000", q.size());
      end
   endtask

   task automatic test_glitch();
      int   exp_p[3]  = '{1500, 0, 1500};
      int   exp_r[3]  = '{2000, 500, 2500};
      logic exp_e[3]  = '{1'b0, 1'b1, 1'b0};
      smp_t s;
      do_reset();
      phase(1'b0, 20);
      phase(1'b1, 1500 * T);
      phase(1'b0, 500 * T);
      phase(1'b1, 1);
      phase(1'b0, 500 * T);
      phase(1'b1, 1500 * T);
      phase(1'b0, 1000 * T);
      phase(1'b1, 20);
      n_cmp++;
      if (q.size() != 3) begin
         n_fail++; $display("FAIL glitch_count: got %0d want 3", q.size());
      end
      for (int i = 0; i < 3; i++) begin
         s = (i < q.size()) ? q[i] : '1;
         n_cmp++;
         if (s.pulse !== 16'(exp_p[i]) || s.period !== 16'(exp_r[i]) || s.rerr !== exp_e[i]) begin
            n_fail++;
            $display("FAIL glitch_%0d: got %0d/%0d/%b want %0d/%0d/%b", i, s.pulse, s.period,
                     s.rerr, exp_p[i], exp_r[i], exp_e[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_range();
      test_rounding();
      test_lost();
      test_reset_mid();
      test_glitch();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
